// File: rtl/axi_pkg.sv
// axi_pkg: bridge FSM encoding and fixed AXI3 field constants
package axi_pkg;
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_REQ, WR_B} state_t;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;
  localparam logic [3:0] LEN_1 = 4'd0;
endpackage

// File: rtl/axi_wstrb_gen.sv
// axi_wstrb_gen: byte-lane strobe from transfer size and low address bits
module axi_wstrb_gen
  import axi_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr,
  output logic [3:0] wstrb
);
  always_comb wstrb = size == SIZE_B ? 4'b0001 << addr :
                      size == SIZE_H ? (addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
endmodule

// File: rtl/d_sram_like_to_axi.sv
// d_sram_like_to_axi: one SRAM-like data request to one single-beat AXI3 transaction
module d_sram_like_to_axi
  import axi_pkg::*;
#(
  parameter logic [3:0] ID = 4'b0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);
  state_t state, state_n;
  logic [31:0] addr_r, wdata_r;
  logic [1:0]  size_r;
  logic        aw_done, w_done, aw_hs, w_hs, wr_both;
  logic        unused;
  assign unused = ^{rid, rresp, rlast, bid, bresp};
  axi_wstrb_gen u_wstrb (.size(size_r), .addr(addr_r[1:0]), .wstrb(wstrb));
  assign arid = ID;
  assign awid = ID;
  assign wid = ID;
  assign araddr = addr_r;
  assign awaddr = addr_r;
  assign arsize = {1'b0, size_r};
  assign awsize = {1'b0, size_r};
  assign arlen = LEN_1;
  assign awlen = LEN_1;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arlock = '0;
  assign awlock = '0;
  assign arcache = '0;
  assign awcache = '0;
  assign arprot = '0;
  assign awprot = '0;
  assign wlast = 1'b1;
  assign wdata = wdata_r;
  always_comb begin
    data_addr_ok = state == IDLE && data_req;
    arvalid = state == RD_AR;
    rready = state == RD_R;
    awvalid = state == WR_REQ && !aw_done;
    wvalid = state == WR_REQ && !w_done;
    bready = state == WR_B;
    aw_hs = awvalid && awready;
    w_hs = wvalid && wready;
    wr_both = (aw_done || aw_hs) && (w_done || w_hs);
    data_data_ok = (state == RD_R && rvalid) || (state == WR_B && bvalid);
    data_rdata = state == RD_R ? rdata : '0;
    state_n = state;
    case (state)
      IDLE:    state_n = data_req ? (data_wr ? WR_REQ : RD_AR) : IDLE;
      RD_AR:   state_n = arready ? RD_R : RD_AR;
      RD_R:    state_n = rvalid ? IDLE : RD_R;
      WR_REQ:  state_n = wr_both ? WR_B : WR_REQ;
      WR_B:    state_n = bvalid ? IDLE : WR_B;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      aw_done <= 1'b0;
      w_done <= 1'b0;
      addr_r <= '0;
      size_r <= '0;
      wdata_r <= '0;
    end else begin
      state <= state_n;
      if (data_addr_ok) begin
        addr_r <= data_addr;
        size_r <= data_size;
        wdata_r <= data_wdata;
      end
      aw_done <= state == WR_REQ && !wr_both && (aw_done || aw_hs);
      w_done <= state == WR_REQ && !wr_both && (w_done || w_hs);
    end
  end
endmodule

// File: tb/tb_d_sram_like_to_axi.sv
// tb_d_sram_like_to_axi: directed cycle-by-cycle checks of the data-side SRAM-like to AXI bridge
module tb_d_sram_like_to_axi;
  logic        clk = 0, rst = 1;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        data_addr_ok, data_data_ok;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  int total = 0, bad = 0, ok_cnt;
  always #5 clk = ~clk;
  d_sram_like_to_axi dut (
    .clk(clk), .rst(rst), .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );
  task chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task step;
    @(posedge clk);
    #1;
  endtask
  task samp;
    @(negedge clk);
  endtask
  task quiet;
    data_req = 0; data_wr = 0; data_size = 0; data_addr = 0; data_wdata = 0;
    arready = 0; rid = 4'h1; rdata = 0; rresp = 0; rlast = 1; rvalid = 0;
    awready = 0; wready = 0; bid = 4'h1; bresp = 0; bvalid = 0;
  endtask
  task req(input logic wr, input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
  endtask
  initial begin
    quiet();
    repeat (2) step();
    rst = 0;
    samp();
    chk("rst_addr_ok", data_addr_ok, 0);
    chk("rst_data_ok", data_data_ok, 0);
    chk("rst_valids", {arvalid, awvalid, wvalid}, 0);
    chk("rst_readies", {rready, bready}, 0);
    chk("rst_rdata", data_rdata, 0);
    // word read, fastest handshakes
    step(); req(0, 2, 32'h1FC0_0004, 0); samp();
    chk("rd_addr_ok", data_addr_ok, 1);
    chk("rd_arvalid_c0", arvalid, 0);
    step(); quiet(); arready = 1; samp();
    chk("rd_arvalid", arvalid, 1);
    chk("rd_araddr", araddr, 32'h1FC0_0004);
    chk("rd_arsize", arsize, 2);
    chk("rd_fixed", {arid, arlen, arburst, arlock, arcache, arprot}, {4'h1, 4'h0, 2'b01, 2'b0, 4'h0, 3'h0});
    chk("rd_addr_ok_c1", data_addr_ok, 0);
    step(); quiet(); rvalid = 1; rdata = 32'hDEADBEEF; samp();
    chk("rd_rready", rready, 1);
    chk("rd_data_ok", data_data_ok, 1);
    chk("rd_rdata", data_rdata, 32'hDEADBEEF);
    step(); quiet(); samp();
    chk("rd_done", {data_data_ok, rready, arvalid}, 0);
    // byte write at lane 3
    step(); req(1, 0, 32'h0000_1003, 32'hAB00_0000); samp();
    chk("wb_addr_ok", data_addr_ok, 1);
    step(); quiet(); awready = 1; wready = 1; samp();
    chk("wb_valids", {awvalid, wvalid}, 2'b11);
    chk("wb_awaddr", awaddr, 32'h0000_1003);
    chk("wb_awsize", awsize, 0);
    chk("wb_wstrb", wstrb, 4'b1000);
    chk("wb_wlast", wlast, 1);
    chk("wb_wdata", wdata, 32'hAB00_0000);
    chk("wb_ids", {awid, wid, awburst, awlen}, {4'h1, 4'h1, 2'b01, 4'h0});
    step(); quiet(); bvalid = 1; samp();
    chk("wb_bready", bready, 1);
    chk("wb_valids_off", {awvalid, wvalid}, 0);
    chk("wb_data_ok", data_data_ok, 1);
    step(); quiet(); samp();
    chk("wb_done", {data_data_ok, bready}, 0);
    // half write, W handshake three cycles ahead of AW
    step(); req(1, 1, 32'h0000_2002, 32'h5A5A_0000); samp();
    chk("wh_addr_ok", data_addr_ok, 1);
    step(); quiet(); wready = 1; samp();
    chk("wh_valids", {awvalid, wvalid}, 2'b11);
    chk("wh_wstrb", wstrb, 4'b1100);
    chk("wh_awsize", awsize, 1);
    for (int i = 0; i < 2; i++) begin
      step(); quiet(); samp();
      chk("wh_wait", {awvalid, wvalid, bready}, 3'b100);
    end
    step(); quiet(); awready = 1; samp();
    chk("wh_aw", {awvalid, wvalid, bready}, 3'b100);
    step(); quiet(); bvalid = 1; samp();
    chk("wh_b", {awvalid, wvalid, bready, data_data_ok}, 4'b0011);
    step(); quiet(); samp();
    chk("wh_done", {data_data_ok, bready, awvalid, wvalid}, 0);
    // word write, AW first then W; also exercise size 3 as word strobe
    step(); req(1, 3, 32'h0000_3001, 32'h1122_3344); samp();
    step(); quiet(); awready = 1; samp();
    chk("ww_wstrb", wstrb, 4'b1111);
    step(); quiet(); samp();
    chk("ww_wait", {awvalid, wvalid, bready}, 3'b010);
    step(); quiet(); wready = 1; samp();
    chk("ww_w", {awvalid, wvalid, bready}, 3'b010);
    step(); quiet(); bvalid = 1; samp();
    chk("ww_b", {bready, data_data_ok}, 2'b11);
    // stalled read with SLVERR response
    step(); quiet(); req(0, 2, 32'h8000_0010, 0); samp();
    chk("rs_addr_ok", data_addr_ok, 1);
    for (int i = 0; i < 5; i++) begin
      step(); quiet(); data_addr = 32'hFFFF_FFFF; samp();
      chk("rs_arvalid", arvalid, 1);
      chk("rs_araddr", araddr, 32'h8000_0010);
    end
    step(); quiet(); arready = 1; samp();
    chk("rs_arvalid_hs", arvalid, 1);
    ok_cnt = 0;
    step(); quiet(); rvalid = 1; rresp = 2'b10; rdata = 32'h1234_5678; samp();
    chk("rs_rdata", data_rdata, 32'h1234_5678);
    ok_cnt += data_data_ok;
    for (int i = 0; i < 3; i++) begin
      step(); quiet(); rvalid = 1; samp();
      ok_cnt += data_data_ok;
    end
    chk("rs_ok_pulses", ok_cnt, 1);
    // stray rvalid in IDLE must not be consumed
    chk("stray_rready", rready, 0);
    // back-to-back with data_req held
    step(); quiet(); req(0, 2, 32'h0000_0100, 0); samp();
    chk("bb_ok0", data_addr_ok, 1);
    step(); arready = 1; samp();
    chk("bb_ok1", {data_addr_ok, arvalid}, 2'b01);
    step(); arready = 0; rvalid = 1; rdata = 32'hCAFE_0001; samp();
    chk("bb_ok2", {data_addr_ok, data_data_ok}, 2'b01);
    step(); rvalid = 0; data_addr = 32'h0000_0200; samp();
    chk("bb_ok3", {data_addr_ok, arvalid, data_data_ok}, 3'b100);
    step(); quiet(); arready = 1; samp();
    chk("bb_araddr2", araddr, 32'h0000_0200);
    step(); quiet(); rvalid = 1; rdata = 32'hCAFE_0002; samp();
    chk("bb_rdata2", data_rdata, 32'hCAFE_0002);
    // reset in RD_R
    step(); quiet(); req(0, 2, 32'h0000_0400, 0); samp();
    step(); quiet(); arready = 1; samp();
    step(); quiet(); rst = 1; samp();
    chk("rr_in_rd_r", rready, 1);
    step(); rst = 0; rvalid = 1; rdata = 32'h0BAD_0BAD; samp();
    chk("rr_after", {rready, data_data_ok, arvalid}, 0);
    chk("rr_rdata", data_rdata, 0);
    step(); quiet(); req(0, 2, 32'h0000_0500, 0); samp();
    chk("rr2_addr_ok", data_addr_ok, 1);
    step(); quiet(); arready = 1; samp();
    chk("rr2_araddr", araddr, 32'h0000_0500);
    step(); quiet(); rvalid = 1; rdata = 32'h7777_8888; samp();
    chk("rr2_data", {31'b0, data_data_ok}, 1);
    chk("rr2_rdata", data_rdata, 32'h7777_8888);
    step(); quiet(); samp();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/d_sram_like_to_axi.md
# d_sram_like_to_axi

Data-side bridge from the SRAM-like request interface to an AXI3 master port. Sits directly downstream of the data SRAM→SRAM-like converter and upstream of the AXI interconnect/crossbar. Converts one SRAM-like read or write into one single-beat AXI transaction. Supports one outstanding transaction at a time.

## Interface
- `ID`, 4'b0001, value driven on arid/awid/wid
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `data_req`  in  1  SRAM-like request valid
- `data_wr`  in  1  1 = write, 0 = read
- `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `data_addr`  in  32  byte address
- `data_wdata`  in  32  write data, lane-aligned
- `data_rdata`  out  32  read data, valid with data_ok
- `data_addr_ok`  out  1  request accepted
- `data_data_ok`  out  1  one-cycle completion pulse
- AR: `arid` out 4, `araddr` out 32, `arlen` out 4, `arsize` out 3, `arburst` out 2, `arlock` out 2, `arcache` out 4, `arprot` out 3, `arvalid` out 1, `arready` in 1
- R: `rid` in 4, `rdata` in 32, `rresp` in 2, `rlast` in 1, `rvalid` in 1, `rready` out 1
- AW: `awid`, `awaddr`, `awlen`, `awsize`, `awburst`, `awlock`, `awcache`, `awprot` (widths as AR), `awvalid` out 1, `awready` in 1
- W: `wid` out 4, `wdata` out 32, `wstrb` out 4, `wlast` out 1, `wvalid` out 1, `wready` in 1
- B: `bid` in 4, `bresp` in 2, `bvalid` in 1, `bready` out 1

## Operation
- FSM states: IDLE, RD_AR, RD_R, WR_REQ, WR_B.
- IDLE:
  - `data_addr_ok = data_req`; only IDLE asserts addr_ok.
  - On accept, latch addr, size, wr and wdata into request registers.
  - Next state is RD_AR if wr = 0, else WR_REQ.
- RD_AR: `arvalid` = 1, held until `arready`, then RD_R.
- RD_R:
  - `rready` = 1.
  - On `rvalid`: `data_data_ok` = 1 that cycle, `data_rdata = rdata`, next state IDLE.
- WR_REQ:
  - `awvalid` and `wvalid` are asserted together.
  - Flags aw_done and w_done record each handshake; each valid drops the cycle after its own handshake.
  - When both handshakes are done (same cycle or different cycles), go to WR_B and clear both flags.
- WR_B:
  - `bready` = 1.
  - On `bvalid`: `data_data_ok` = 1, next state IDLE.
- Fixed fields:
  - arlen/awlen = 0
  - arburst/awburst = 2'b01
  - lock/cache/prot = 0
  - wlast = 1
  - ids = `ID`
- Address and size:
  - araddr/awaddr = latched addr, unaligned low bits kept.
  - arsize/awsize = {1'b0, latched size}.
- wstrb derived from latched size and addr[1:0]:
  - byte: 4'b0001 << addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
  - size 3 is treated as word.
- wdata = latched wdata, passed through unshifted.
- Response handling:
  - rresp/bresp errors are ignored; the transaction still completes with data_ok.
  - rid/bid/rlast are not checked.

## Timing
- Reset values: all valid/ready outputs 0, addr_ok 0, data_ok 0, data_rdata 0 (combinational 0 outside RD_R); FSM in IDLE, flags cleared.
- Read latency, with arready and rvalid at the earliest cycles:
  - addr_ok in cycle 0
  - arvalid in cycle 1
  - data_ok in cycle 2 at the earliest
- Write: awvalid/wvalid in cycle 1, data_ok in cycle 2 at the earliest (bvalid in cycle 2).
- data_ok is combinational from rvalid/bvalid within the proper state; it is exactly one cycle per transaction.
- No back-to-back acceptance: a new addr_ok occurs at the earliest the cycle after data_ok.
- The upstream stage holds data_req high until addr_ok and does not re-request before data_ok; the bridge requires no other stability from it.
- rvalid or bvalid arriving outside RD_R/WR_B is not consumed (ready is 0).
- Reset mid-transaction: FSM returns to IDLE, all valids drop, and no data_ok is issued.

## Structure
- Shared package `axi_pkg` holds:
  - FSM state encoding
  - AXI constants: BURST_INCR, SIZE_B/H/W, LEN_1
- Sub-module `axi_wstrb_gen`: combinational (size, addr[1:0]) → wstrb.

## Test plan
- Word read at 0x1FC0_0004, arready immediate, rvalid next cycle with rdata 0xDEADBEEF → araddr 0x1FC0_0004, arsize 2, data_ok one cycle with data_rdata 0xDEADBEEF, 2 cycles after addr_ok.
- Byte write 0xAB at addr 0x…03 → awsize 0, wstrb 4'b1000, wlast 1, data_ok on bvalid.
- Write with wready 3 cycles before awready → wvalid drops after the W handshake, awvalid is held, WR_B is entered only after the AW handshake.
- Read with arready stalled 5 cycles and rresp = SLVERR → arvalid and araddr stay stable throughout; data_ok still pulses once.
- Back-to-back requests with data_req held high → addr_ok again only in the cycle after data_ok; no overlapping transactions on AXI.
- rst asserted during RD_R → next cycle IDLE, rready 0, no data_ok; a following read completes normally.
